// File: rtl/fetch_pc_pipe.sv
// fetch_pc_pipe: next-PC select, instruction register, fetch-valid flag and PC history for the fetch stage
module fetch_pc_pipe #(
  parameter int AW = 32,
  parameter int IW = 32,
  parameter int HIST = 2,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter bit FLUSH = 1'b1
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IW-1:0]      instruction,
  input  logic               stall,
  input  logic [1:0]         bs,
  input  logic               ps,
  input  logic               z,
  input  logic [AW-1:0]      bra,
  input  logic [AW-1:0]      raa,
  output logic [AW-1:0]      pc,
  output logic [IW-1:0]      ir,
  output logic               ir_valid,
  output logic [AW*HIST-1:0] pc_hist,
  output logic               redirect
);
  logic [1:0] sel;
  logic [AW-1:0] next_pc;
  logic taken;
  always_comb begin
    sel = {bs[1], ((ps ^ z) | bs[1]) & bs[0]};
    next_pc = sel == 2'b00 ? pc + AW'(1) : sel == 2'b10 ? raa : bra;
    taken = sel != 2'b00;
    redirect = taken & ~stall & reset_n;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      pc <= RESET_PC;
      ir <= '0;
      ir_valid <= 1'b0;
      pc_hist <= '0;
    end else if (!stall) begin
      pc <= next_pc;
      pc_hist <= (pc_hist << AW) | (AW*HIST)'(pc);
      ir <= FLUSH && taken ? '0 : instruction;
      ir_valid <= !(FLUSH && taken);
    end
endmodule

// File: tb/tb_fetch_pc_pipe.sv
// tb_fetch_pc_pipe: directed scoreboard bench for fetch_pc_pipe (FLUSH=1/AW=32 and FLUSH=0/AW=4 instances)
module tb_fetch_pc_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0, stall = 1'b1, ps = 1'b0, z = 1'b0, redirect, ir_valid;
  logic [1:0] bs = 2'b11;
  logic [31:0] bra = 32'h20, raa = '0, pc, ir, instruction;
  logic [63:0] pc_hist;
  assign instruction = 32'hA0 + pc;
  fetch_pc_pipe #(.AW(32), .IW(32), .HIST(2), .RESET_PC(32'h0), .FLUSH(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .stall(stall), .bs(bs),
    .ps(ps), .z(z), .bra(bra), .raa(raa), .pc(pc), .ir(ir), .ir_valid(ir_valid),
    .pc_hist(pc_hist), .redirect(redirect));
  logic reset_n2 = 1'b0, stall2 = 1'b1, ps2 = 1'b0, z2 = 1'b0, redirect2, ir_valid2;
  logic [1:0] bs2 = 2'b00;
  logic [3:0] bra2 = '0, raa2 = '0, pc2;
  logic [7:0] pc_hist2;
  logic [31:0] ir2, instruction2;
  assign instruction2 = 32'hB0 + {28'b0, pc2};
  fetch_pc_pipe #(.AW(4), .IW(32), .HIST(2), .RESET_PC(4'h2), .FLUSH(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n2), .instruction(instruction2), .stall(stall2), .bs(bs2),
    .ps(ps2), .z(z2), .bra(bra2), .raa(raa2), .pc(pc2), .ir(ir2), .ir_valid(ir_valid2),
    .pc_hist(pc_hist2), .redirect(redirect2));
  typedef struct {string name; int f; logic [31:0] v;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  task automatic expect_val(input string n, input int f, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.f = f;
    e.v = v;
    q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] actual(input int f);
    case (f)
      0: return pc;
      1: return ir;
      2: return {31'b0, ir_valid};
      3: return pc_hist[31:0];
      4: return pc_hist[63:32];
      5: return {31'b0, redirect};
      6: return {28'b0, pc2};
      7: return ir2;
      8: return {31'b0, ir_valid2};
      default: return {31'b0, redirect2};
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.f);
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.v);
      end
    end
  task automatic main_state(input string n, input logic [31:0] p, input logic [31:0] i,
                            input logic v, input logic [31:0] h0, input logic [31:0] h1);
    expect_val({n, " pc"}, 0, p);
    expect_val({n, " ir"}, 1, i);
    expect_val({n, " ir_valid"}, 2, {31'b0, v});
    expect_val({n, " hist0"}, 3, h0);
    expect_val({n, " hist1"}, 4, h1);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    cyc();
    cyc();
    main_state("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    expect_val("reset redirect", 5, 32'h0);
    checks++;
    if (pc !== 32'h0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL direct reset: got pc %h ir_valid %b expected pc 0 ir_valid 0", pc, ir_valid);
    end
    reset_n = 1'b1; stall = 1'b0; bs = 2'b00;
    expect_val("seq redirect", 5, 32'h0);
    repeat (4) cyc();
    main_state("seq", 32'h4, 32'hA3, 1'b1, 32'h3, 32'h2);
    checks++;
    if (ir !== 32'hA3) begin
      errors++;
      $display("FAIL direct seq ir: got %h expected a3", ir);
    end
    cyc();
    bs = 2'b01; ps = 1'b0; z = 1'b1; bra = 32'h40;
    expect_val("cond taken redirect", 5, 32'h1);
    cyc();
    main_state("cond taken", 32'h40, 32'h0, 1'b0, 32'h5, 32'h4);
    bs = 2'b11; bra = 32'h5;
    cyc();
    expect_val("jump back pc", 0, 32'h5);
    bs = 2'b01; z = 1'b0;
    expect_val("cond not taken redirect", 5, 32'h0);
    cyc();
    main_state("cond not taken", 32'h6, 32'hA5, 1'b1, 32'h5, 32'h40);
    bs = 2'b11; bra = 32'h8;
    cyc();
    bs = 2'b10; raa = 32'h100; ps = 1'bx; z = 1'bx;
    expect_val("regjump redirect", 5, 32'h1);
    cyc();
    main_state("regjump", 32'h100, 32'h0, 1'b0, 32'h8, 32'h6);
    checks++;
    if (pc !== 32'h100) begin
      errors++;
      $display("FAIL direct regjump pc: got %h expected 100", pc);
    end
    bs = 2'b00;
    expect_val("seq x flags redirect", 5, 32'h0);
    cyc();
    main_state("pre-stall", 32'h101, 32'h1A0, 1'b1, 32'h100, 32'h8);
    ps = 1'b0; z = 1'b0;
    stall = 1'b1; bs = 2'b11; bra = 32'h20;
    for (int i = 0; i < 3; i++) begin
      expect_val("stall redirect", 5, 32'h0);
      cyc();
      main_state("stall", 32'h101, 32'h1A0, 1'b1, 32'h100, 32'h8);
    end
    stall = 1'b0;
    expect_val("unstall redirect", 5, 32'h1);
    cyc();
    main_state("unstall jump", 32'h20, 32'h0, 1'b0, 32'h101, 32'h100);
    checks++;
    if (pc !== 32'h20) begin
      errors++;
      $display("FAIL direct unstall pc: got %h expected 20", pc);
    end
    expect_val("d2 reset pc", 6, 32'h2);
    expect_val("d2 reset ir", 7, 32'h0);
    expect_val("d2 reset ir_valid", 8, 32'h0);
    reset_n2 = 1'b1; stall2 = 1'b0; bs2 = 2'b00;
    cyc();
    expect_val("d2 first pc", 6, 32'h3);
    expect_val("d2 first ir", 7, 32'hB2);
    expect_val("d2 first ir_valid", 8, 32'h1);
    bs2 = 2'b11; bra2 = 4'h8;
    cyc();
    expect_val("d2 jump pc", 6, 32'h8);
    expect_val("d2 jump ir kept", 7, 32'hB3);
    bs2 = 2'b10; raa2 = 4'hE;
    expect_val("d2 regjump redirect", 9, 32'h1);
    cyc();
    expect_val("d2 regjump pc", 6, 32'hE);
    expect_val("d2 regjump ir kept", 7, 32'hB8);
    expect_val("d2 regjump ir_valid", 8, 32'h1);
    bs2 = 2'b00;
    cyc();
    expect_val("d2 pc F", 6, 32'hF);
    cyc();
    expect_val("d2 wrap pc", 6, 32'h0);
    expect_val("d2 wrap ir", 7, 32'hBF);
    stall2 = 1'b1; reset_n2 = 1'b0; bs2 = 2'b11;
    expect_val("d2 reset redirect", 9, 32'h0);
    cyc();
    expect_val("d2 rereset pc", 6, 32'h2);
    expect_val("d2 rereset ir_valid", 8, 32'h0);
    expect_val("d2 rereset ir", 7, 32'h0);
    repeat (2) @(negedge clk);
    if (checks < 12) begin
      errors++;
      $display("FAIL check count: got %0d expected at least 12", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
